// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit (mdu_iter).
package mdu_pkg;

  localparam int MDU_OP_W = 3;
  localparam int MDU_ST_W = 2;

  typedef enum logic [MDU_OP_W-1:0] {
    OP_NONE = 3'd0,
    OP_MUL  = 3'd1,
    OP_DIV  = 3'd2,
    OP_MADD = 3'd3,
    OP_MSUB = 3'd4,
    OP_MTHI = 3'd5,
    OP_MTLO = 3'd6
  } mdu_op_t;

  typedef enum logic [MDU_ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

  // Ops that run through the iterative datapath and stall the pipeline.
  function automatic logic mdu_is_iter_op(input logic [MDU_OP_W-1:0] f);
    logic r;
    case (f)
      OP_MUL, OP_DIV, OP_MADD, OP_MSUB: r = 1'b1;
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One combinational radix-2 step: shift-add for multiply, restoring trial subtract for divide.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 div_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [2*WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]     opb_i,
  output logic [2*WIDTH-1:0]   acc_o,
  output logic [2*WIDTH-1:0]   mcand_o,
  output logic [WIDTH-1:0]     opb_o
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] trial_s;
  logic           ge_s;

  // For divide, acc holds {remainder, dividend/quotient}; for multiply, the running product.
  always_comb begin
    shifted_s = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, opb_i};
    ge_s      = (shifted_s >= {1'b0, opb_i});
    if (div_i) begin
      acc_o   = {(ge_s ? trial_s[WIDTH-1:0] : shifted_s[WIDTH-1:0]), acc_i[WIDTH-2:0], ge_s};
      mcand_o = mcand_i;
      opb_o   = opb_i;
    end else begin
      acc_o   = opb_i[0] ? (acc_i + mcand_i) : acc_i;
      mcand_o = {mcand_i[2*WIDTH-2:0], 1'b0};
      opb_o   = {1'b0, opb_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO accumulator for the EX stage.
// Optional macro MDU_EARLY_OUT_EN: multiplies stop once the remaining multiplier is zero.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                reg_stall,
  input  logic                reg_flush,
  output logic                alu_stall,
  input  logic                sign,
  input  logic [MDU_OP_W-1:0] func,
  input  logic [WIDTH-1:0]    source_a,
  input  logic [WIDTH-1:0]    source_b,
  output logic [WIDTH-1:0]    hi,
  output logic [WIDTH-1:0]    lo,
  output logic                div_zero,
  output logic                busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mdu_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MDU_OP_W-1:0] op_q, op_d;
  logic                neg_q, neg_d;
  logic                neg_rem_q, neg_rem_d;
  logic                bzero_q, bzero_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [2*WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]    opb_q, opb_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic                div_zero_q, div_zero_d;
  logic                busy_q, busy_d;

  logic                issue_s;
  logic                sa_s, sb_s;
  logic [WIDTH-1:0]    abs_a_s, abs_b_s;
  logic [2*WIDTH-1:0]  acc_nx_s, mcand_nx_s;
  logic [WIDTH-1:0]    opb_nx_s;
  logic                last_s;
  logic [2*WIDTH-1:0]  prod_s;
  logic [WIDTH-1:0]    quot_s, rem_s;
  logic [2*WIDTH-1:0]  fix_hilo_s;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div_i   (op_q == OP_DIV),
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .opb_i   (opb_q),
    .acc_o   (acc_nx_s),
    .mcand_o (mcand_nx_s),
    .opb_o   (opb_nx_s)
  );

  // Operand magnitudes, issue detection and last-iteration detection.
  always_comb begin
    issue_s = (state_q == ST_IDLE) && mdu_is_iter_op(func) && !reg_flush;
    sa_s    = sign & source_a[WIDTH-1];
    sb_s    = sign & source_b[WIDTH-1];
    abs_a_s = sa_s ? (-source_a) : source_a;
    abs_b_s = sb_s ? (-source_b) : source_b;
`ifdef MDU_EARLY_OUT_EN
    last_s  = (cnt_q == CNT_W'(1)) || ((op_q != OP_DIV) && (opb_nx_s == {WIDTH{1'b0}}));
`else
    last_s  = (cnt_q == CNT_W'(1));
`endif
  end

  // Sign correction and HI/LO commit value used in FIX.
  always_comb begin
    prod_s = neg_q ? (-acc_q) : acc_q;
    quot_s = neg_q ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem_s  = neg_rem_q ? (-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MUL:  fix_hilo_s = prod_s;
      OP_MADD: fix_hilo_s = {hi_q, lo_q} + prod_s;
      OP_MSUB: fix_hilo_s = {hi_q, lo_q} - prod_s;
      OP_DIV:  fix_hilo_s = {rem_s, quot_s};
      default: fix_hilo_s = {hi_q, lo_q};
    endcase
  end

  // Next-state logic for the FSM, datapath and architectural HI/LO.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    bzero_d    = bzero_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    opb_d      = opb_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    if (reg_flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue_s) begin
            state_d    = ST_ITER;
            cnt_d      = CNT_W'(WIDTH);
            op_d       = func;
            neg_d      = sa_s ^ sb_s;
            neg_rem_d  = sa_s;
            bzero_d    = (source_b == {WIDTH{1'b0}});
            acc_d      = (func == OP_DIV) ? {{WIDTH{1'b0}}, abs_a_s} : {(2*WIDTH){1'b0}};
            mcand_d    = {{WIDTH{1'b0}}, abs_a_s};
            opb_d      = abs_b_s;
            div_zero_d = 1'b0;
          end else if (!reg_stall && (func == OP_MTHI)) begin
            hi_d = source_a;
          end else if (!reg_stall && (func == OP_MTLO)) begin
            lo_d = source_a;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ITER: begin
          acc_d   = acc_nx_s;
          mcand_d = mcand_nx_s;
          opb_d   = opb_nx_s;
          cnt_d   = cnt_q - CNT_W'(1);
          if (last_s) begin
            state_d = ST_FIX;
          end else begin
            state_d = ST_ITER;
          end
        end
        ST_FIX: begin
          {hi_d, lo_d} = fix_hilo_s;
          div_zero_d   = (op_q == OP_DIV) && bzero_q;
          state_d      = ST_DONE;
        end
        ST_DONE: begin
          if (!reg_stall) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and architectural registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      op_q       <= OP_NONE;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      bzero_q    <= 1'b0;
      acc_q      <= {(2*WIDTH){1'b0}};
      mcand_q    <= {(2*WIDTH){1'b0}};
      opb_q      <= {WIDTH{1'b0}};
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      bzero_q    <= bzero_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      opb_q      <= opb_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
    end
  end

  // The stall is released while in reset and once the op reaches DONE.
  always_comb begin
    alu_stall = rst && (issue_s || (state_q == ST_ITER) || (state_q == ST_FIX));
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter (WIDTH=32); honours MDU_EARLY_OUT_EN.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk;
  logic        rst;
  logic        reg_stall;
  logic        reg_flush;
  logic        alu_stall;
  logic        sign;
  logic [2:0]  func;
  logic [31:0] source_a;
  logic [31:0] source_b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int n;
  int exp_short;

  mdu_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .reg_stall (reg_stall),
    .reg_flush (reg_flush),
    .alu_stall (alu_stall),
    .sign      (sign),
    .func      (func),
    .source_a  (source_a),
    .source_b  (source_b),
    .hi        (hi),
    .lo        (lo),
    .div_zero  (div_zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one op at a negedge and counts alu_stall cycles (bounded); returns at a negedge.
  task automatic run_op(input logic [2:0] f, input logic s, input logic [31:0] a,
                        input logic [31:0] b, output int cyc);
    func = f; sign = s; source_a = a; source_b = b; cyc = 0;
    #1;
    while (alu_stall === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    func = OP_NONE;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; reg_stall = 1'b0; reg_flush = 1'b0;
    sign = 1'b0; func = OP_MUL; source_a = 32'd3; source_b = 32'd4;
    @(negedge clk); @(negedge clk);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_flags", {61'd0, div_zero, busy, alu_stall}, 64'd0);
    func = OP_NONE;
    rst = 1'b1;
    @(negedge clk);

    run_op(OP_MUL, 1'b1, 32'hFFFF_FFFD, 32'd5, n);
    check("mul_s_stall", 64'(n), 64'd34);
    check("mul_s_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    check("mul_s_busy", {63'd0, busy}, 64'd0);

    run_op(OP_DIV, 1'b0, 32'd100, 32'd7, n);
    check("div_u_stall", 64'(n), 64'd34);
    check("div_u_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

    run_op(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, n);
    check("div_s_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    func = OP_MTHI; source_a = 32'd0; #1;
    check("mthi_nostall", {63'd0, alu_stall}, 64'd0);
    @(negedge clk);
    func = OP_MTLO; source_a = 32'hFFFF_FFFF;
    @(negedge clk);
    func = OP_NONE;
    check("mt_hilo", {hi, lo}, 64'h0000_0000_FFFF_FFFF);

    run_op(OP_MADD, 1'b0, 32'd1, 32'd1, n);
    check("madd_hilo", {hi, lo}, 64'h0000_0001_0000_0000);
    run_op(OP_MSUB, 1'b1, 32'd1, 32'd1, n);
    check("msub_hilo", {hi, lo}, 64'h0000_0000_FFFF_FFFF);

    run_op(OP_DIV, 1'b0, 32'h0000_1234, 32'd0, n);
    check("divz_flag", {63'd0, div_zero}, 64'd1);
    check("divz_hilo", {hi, lo}, 64'h0000_1234_FFFF_FFFF);

    func = OP_MUL; sign = 1'b1; source_a = 32'd6; source_b = 32'd7;
    @(negedge clk);
    check("divz_clear", {62'd0, div_zero, busy}, 64'd1);
    run_op(OP_MUL, 1'b1, 32'd6, 32'd7, n);
    check("mul_after_divz", {hi, lo}, 64'h0000_0000_0000_002A);

    // Flush on the 10th iteration of a divide.
    func = OP_DIV; sign = 1'b0; source_a = 32'd1000; source_b = 32'd3;
    @(negedge clk);
    func = OP_NONE;
    repeat (9) @(negedge clk);
    reg_flush = 1'b1;
    @(negedge clk);
    reg_flush = 1'b0; #1;
    check("flush_idle", {62'd0, busy, alu_stall}, 64'd0);
    check("flush_hilo", {hi, lo}, 64'h0000_0000_0000_002A);
    check("flush_divz", {63'd0, div_zero}, 64'd0);
    @(negedge clk);

    run_op(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("div_minint", {hi, lo}, 64'h0000_0000_8000_0000);

    run_op(OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    check("mul_u_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // Pipeline stall held across the op: no effect on iteration, DONE holds, MTHI ignored.
    reg_stall = 1'b1;
    run_op(OP_MUL, 1'b0, 32'd9, 32'd9, n);
    check("stall_cycles", 64'(n), 64'd34);
    check("stall_done_busy", {62'd0, busy, alu_stall}, 64'd2);
    func = OP_MTHI; source_a = 32'hDEAD_BEEF;
    @(negedge clk);
    check("stall_done_hold", {hi, lo}, 64'h0000_0000_0000_0051);
    check("stall_done_busy2", {63'd0, busy}, 64'd1);
    func = OP_NONE; reg_stall = 1'b0;
    @(negedge clk);
    check("stall_release", {63'd0, busy}, 64'd0);

`ifdef MDU_EARLY_OUT_EN
    exp_short = 4;
`else
    exp_short = 34;
`endif
    run_op(OP_MUL, 1'b0, 32'd7, 32'd3, n);
    check("mul_7x3", {hi, lo}, 64'd21);
    check("mul_7x3_stall", 64'(n), 64'(exp_short));
`ifdef MDU_EARLY_OUT_EN
    exp_short = 3;
`endif
    run_op(OP_MUL, 1'b0, 32'd7, 32'd0, n);
    check("mul_x0", {hi, lo}, 64'd0);
    check("mul_x0_stall", 64'(n), 64'(exp_short));

    run_op(OP_MUL, 1'b0, 32'd3, 32'd5, n);
    // Asynchronous reset mid-multiply.
    func = OP_MUL; source_a = 32'd3; source_b = 32'd5;
    @(negedge clk);
    func = OP_NONE;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", {63'd0, busy}, 64'd1);
    rst = 1'b0; #1;
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    check("rst_mid_flags", {61'd0, div_zero, busy, alu_stall}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit with HI/LO accumulator for the EX stage.
- Successor to the fixed-32-bit multi-cycle ALU.
- Adds width generality, signed/unsigned multiply-accumulate (MADD/MSUB) and a divide-by-zero flag.
- Stalls the pipeline through alu_stall while an operation is in flight; HI/LO are architectural registers held inside the block.

Parameters:
- WIDTH, 32, operand/HI/LO width (even, >= 8).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- reg_stall  in  1  EX/MEM pipeline register stall
- reg_flush  in  1  EX pipeline register flush; aborts any in-flight op
- alu_stall  out  1  combinational; holds the pipeline while the op in EX is unfinished
- sign  in  1  1 = signed operands
- func  in  3  mdu_op_t: NONE, MUL, DIV, MADD, MSUB, MTHI, MTLO
- source_a  in  WIDTH  multiplicand/dividend; MTHI/MTLO data
- source_b  in  WIDTH  multiplier/divisor
- hi  out  WIDTH  registered HI
- lo  out  WIDTH  registered LO
- div_zero  out  1  registered; set by DIV with source_b==0, cleared by next MUL/DIV/MADD/MSUB issue
- busy  out  1  registered; state != IDLE

Behaviour:
- Reset (rst=0, async): hi=0, lo=0, div_zero=0, busy=0, state IDLE, counter 0. alu_stall=0 while in reset.
- States: IDLE, ITER, FIX, DONE.
- Issue: in IDLE, a func of MUL/DIV/MADD/MSUB, no reg_flush:
  - latch |a|, |b|, result signs, op; counter=WIDTH; go to ITER.
  - alu_stall=1 combinationally in the issue cycle.
- ITER: one radix-2 step per cycle.
  - Multiply: shift-add into a 2*WIDTH product.
  - Divide: restoring shift-subtract, quotient and remainder registers.
  - Counter decrements; ITER->FIX when the counter reaches 1 (WIDTH cycles total).
- FIX (1 cycle): apply signs and commit at the clock edge.
  - Signed product negated if sa^sb.
  - Quotient negated if sa^sb; remainder negated if sa.
  - MUL: {hi,lo}=product.
  - MADD: {hi,lo}+=product; MSUB: {hi,lo}-=product; both mod 2^(2*WIDTH).
  - DIV: lo=quotient, hi=remainder.
  - Then go to DONE.
- alu_stall=1 in issue, ITER and FIX cycles: WIDTH+2 cycles total. alu_stall=0 in DONE.
- DONE: leave to IDLE when reg_stall=0; otherwise hold (no re-issue of the same op). alu_stall=0 throughout DONE.
- MTHI/MTLO:
  - Take effect only in IDLE with reg_stall=0 and reg_flush=0.
  - Write source_a at the edge; no stall.
  - Ignored in any other state.
- reg_flush in any state: go to IDLE next edge; hi/lo/div_zero untouched; alu_stall=0 from the cycle after.
- Divide by zero (restoring result, unsigned magnitudes):
  - Quotient = all ones, remainder = |a|, then sign fix as usual.
  - div_zero=1 at the FIX edge.
- Signed DIV of MIN_INT by -1: lo=MIN_INT, hi=0 (natural wrap, no trap).
- reg_stall during ITER/FIX has no effect on iteration.

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
- Defined:
  - Multiply ITER ends after the cycle in which the remaining (shifted) multiplier magnitude becomes zero.
  - b==0 takes 1 iteration.
  - Total stall = 2 + max(1, bit length of |b|).
  - Divide unchanged.
- Undefined: all multiplies take WIDTH iterations; early-out logic absent.

Decomposition:
- Package mdu_pkg:
  - typedef enum mdu_op_t (3 bits)
  - typedef enum mdu_state_t
  - constants MDU_OP_W, MDU_ST_W
- One sub-module, mdu_step: combinational single radix-2 step (mul add or div trial subtract) parametrised by WIDTH. The FSM, counter and HI/LO live in mdu_iter.

Test Plan (WIDTH=32, macro off unless stated):
- MUL sign=1, a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; alu_stall high exactly 34 cycles.
- DIV sign=0, a=100, b=7 -> lo=0x0000000E, hi=0x00000002. DIV sign=1, a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MTHI 0, MTLO 0xFFFFFFFF, then MADD sign=0, a=1, b=1 -> hi=1, lo=0. MSUB sign=1, a=1, b=1 -> hi=0, lo=0xFFFFFFFF.
- DIV sign=0, a=0x1234, b=0 -> div_zero=1, lo=0xFFFFFFFF, hi=0x1234. Following MUL -> div_zero=0 at issue+1.
- DIV issued, reg_flush at iteration 10 -> state IDLE next cycle, hi/lo unchanged, alu_stall 0. Assert rst low mid-MUL -> hi=lo=0 immediately.
- MDU_EARLY_OUT_EN defined: MUL sign=0, a=7, b=3 -> lo=21, alu_stall high 4 cycles. b=0 -> lo=0, 3 cycles.
